vga_timing_output: RTL

//  Generates 640x480@60 raster timing (x/y scan position) for the pixel renderer.

---
 rtl/vga_timing_output.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_output.sv
// ---------------------------------------------------------------------------
// vga_timing_output
//
// Purpose:
//    Generates 640x480@60 raster timing (x/y scan position) for the pixel
//    renderer and drives the VGA DAC. hsync/vsync/blank are delayed through
//    a PIPE_DELAY-deep shift register so they meet the renderer's registered
//    colour at the pins. A final output register captures sync, blank and
//    expanded colour together, giving PIPE_DELAY+1 cycles of latency from
//    x/y to the pins. frame_tick paces per-frame game-state updates.
//
// Optional feature:
//    VGA_TEST_PATTERN_EN - when defined, pixel_in is ignored and eight
//    vertical colour bars (H_ACTIVE/8 pixels wide) are generated internally
//    from x, delayed by PIPE_DELAY to stay aligned with sync.
//
// Ports:
//    vga_clk      in   1   pixel clock, rising edge
//    rst          in   1   synchronous active-high reset
//    pixel_in     in   8   RRRGGGBB, valid PIPE_DELAY cycles after its x/y
//    x, y         out  10  current raster position (registered counters)
//    active       out  1   x/y inside visible area (undelayed)
//    frame_tick   out  1   one-cycle pulse at (0, V_ACTIVE)
//    vga_hs       out  1   hsync, active low, pin aligned
//    vga_vs       out  1   vsync, active low, pin aligned
//    vga_blank_n  out  1   high during visible pixels, pin aligned
//    vga_r/g/b    out  8   colour to DAC, zero while blanked
// ---------------------------------------------------------------------------
module vga_timing_output #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int PIPE_DELAY = 2
) (
   input  logic       vga_clk,
   input  logic       rst,
   input  logic [7:0] pixel_in,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       active,
   output logic       frame_tick,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic       vga_blank_n,
   output logic [7:0] vga_r,
   output logic [7:0] vga_g,
   output logic [7:0] vga_b
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT_L    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT_L    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_PAST    = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_PAST    = 10'(V_ACTIVE + V_FP + V_SYNC);

   // ------------------------------------------------------------------
   // Raster counters
   // ------------------------------------------------------------------
   logic [9:0] h_cnt_q, h_cnt_d;
   logic [9:0] v_cnt_q, v_cnt_d;

   always_comb begin
      h_cnt_d = h_cnt_q + 10'd1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         // Vertical count only moves on a line wrap.
         if (v_cnt_q == V_LAST) begin
            v_cnt_d = '0;
         end else begin
            v_cnt_d = v_cnt_q + 10'd1;
         end
      end
   end

   always_ff @(posedge vga_clk) begin
      if (rst) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   assign x          = h_cnt_q;
   assign y          = v_cnt_q;
   assign active     = (h_cnt_q < H_ACT_L) && (v_cnt_q < V_ACT_L);
   assign frame_tick = (h_cnt_q == 10'd0) && (v_cnt_q == V_ACT_L);

   // Undelayed sync/blank, decoded straight from the counters.
   logic raw_hs, raw_vs, raw_de;
   assign raw_hs = !((h_cnt_q >= HS_FIRST) && (h_cnt_q < HS_PAST));
   assign raw_vs = !((v_cnt_q >= VS_FIRST) && (v_cnt_q < VS_PAST));
   assign raw_de = active;

   // ------------------------------------------------------------------
   // Alignment shift register: stage gi feeds from stage gi-1, stage 0
   // from the raw decode. Reset loads the inactive levels so no stale
   // sync pulse survives a mid-frame reset.
   // ------------------------------------------------------------------
   logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
   logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;
   logic [PIPE_DELAY-1:0] de_pipe_q, de_pipe_d;

   genvar gi;
   generate
      for (gi = 0; gi < PIPE_DELAY; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            assign hs_pipe_d[gi] = raw_hs;
            assign vs_pipe_d[gi] = raw_vs;
            assign de_pipe_d[gi] = raw_de;
         end else begin : g_rest
            assign hs_pipe_d[gi] = hs_pipe_q[gi-1];
            assign vs_pipe_d[gi] = vs_pipe_q[gi-1];
            assign de_pipe_d[gi] = de_pipe_q[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge vga_clk) begin
      if (rst) begin
         hs_pipe_q <= '1;
         vs_pipe_q <= '1;
         de_pipe_q <= '0;
      end else begin
         hs_pipe_q <= hs_pipe_d;
         vs_pipe_q <= vs_pipe_d;
         de_pipe_q <= de_pipe_d;
      end
   end

   logic hs_dly, vs_dly, de_dly;
   assign hs_dly = hs_pipe_q[PIPE_DELAY-1];
   assign vs_dly = vs_pipe_q[PIPE_DELAY-1];
   assign de_dly = de_pipe_q[PIPE_DELAY-1];

   // ------------------------------------------------------------------
   // Colour source
   // ------------------------------------------------------------------
   logic [7:0] colour_src;

`ifdef VGA_TEST_PATTERN_EN
   localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

   logic [9:0] bar_idx;
   logic [7:0] bar_colour;
   logic [7:0] pat_pipe_q [PIPE_DELAY];
   logic [7:0] pat_pipe_d [PIPE_DELAY];

   assign bar_idx = h_cnt_q / BAR_W;

   always_comb begin
      bar_colour = 8'h00;
      case (bar_idx)
         10'd0:   bar_colour = 8'hFF;
         10'd1:   bar_colour = 8'hE0;
         10'd2:   bar_colour = 8'h1C;
         10'd3:   bar_colour = 8'h03;
         10'd4:   bar_colour = 8'hFC;
         10'd5:   bar_colour = 8'h1F;
         10'd6:   bar_colour = 8'hE3;
         default: bar_colour = 8'h00;
      endcase
   end

   // The pattern stands in for the renderer, so it gets the same latency.
   generate
      for (gi = 0; gi < PIPE_DELAY; gi++) begin : g_pat
         if (gi == 0) begin : g_first
            assign pat_pipe_d[gi] = bar_colour;
         end else begin : g_rest
            assign pat_pipe_d[gi] = pat_pipe_q[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge vga_clk) begin
      if (rst) begin
         pat_pipe_q <= '{default: '0};
      end else begin
         pat_pipe_q <= pat_pipe_d;
      end
   end

   assign colour_src = pat_pipe_q[PIPE_DELAY-1];
`else
   assign colour_src = pixel_in;
`endif

   // ------------------------------------------------------------------
   // Output register: sync, blank and expanded colour leave together.
   // Expansion replicates the MSBs so full-scale codes reach 8'hFF.
   // ------------------------------------------------------------------
   logic [7:0] r_exp, g_exp, b_exp;
   assign r_exp = de_dly ? {colour_src[7:5], colour_src[7:5], colour_src[7:6]} : 8'h00;
   assign g_exp = de_dly ? {colour_src[4:2], colour_src[4:2], colour_src[4:3]} : 8'h00;
   assign b_exp = de_dly ? {4{colour_src[1:0]}} : 8'h00;

   logic       hs_out_q, vs_out_q, blank_n_out_q;
   logic [7:0] r_out_q, g_out_q, b_out_q;

   always_ff @(posedge vga_clk) begin
      if (rst) begin
         hs_out_q      <= 1'b1;
         vs_out_q      <= 1'b1;
         blank_n_out_q <= 1'b0;
         r_out_q       <= '0;
         g_out_q       <= '0;
         b_out_q       <= '0;
      end else begin
         hs_out_q      <= hs_dly;
         vs_out_q      <= vs_dly;
         blank_n_out_q <= de_dly;
         r_out_q       <= r_exp;
         g_out_q       <= g_exp;
         b_out_q       <= b_exp;
      end
   end

   assign vga_hs      = hs_out_q;
   assign vga_vs      = vs_out_q;
   assign vga_blank_n = blank_n_out_q;
   assign vga_r       = r_out_q;
   assign vga_g       = g_out_q;
   assign vga_b       = b_out_q;

endmodule
